// File: rtl/flow_ctrl_pkg.sv
// Typed views of the shared rooth flow codes and controller states, plus the
// RUN-state event decode used by flow_ctrl.
`include "rooth_defines.v"

package flow_ctrl_pkg;

  localparam int FLOW_WIDTH = `FLOW_WIDTH;

  typedef enum logic [FLOW_WIDTH-1:0] {
    FLOW_WORK    = `FLOW_WORK,
    FLOW_STOP    = `FLOW_STOP,
    FLOW_REFRESH = `FLOW_REFRESH
  } flow_e;

  typedef enum logic [1:0] {
    ST_INIT    = `ROOTH_ST_INIT,
    ST_RUN     = `ROOTH_ST_RUN,
    ST_MD_WAIT = `ROOTH_ST_MD_WAIT,
    ST_HALT    = `ROOTH_ST_HALT
  } state_e;

  // Winning event in RUN after priority resolution.
  typedef enum logic [2:0] {
    EV_NONE,
    EV_JUMP,
    EV_MD,
    EV_HALT,
    EV_LD
  } run_ev_e;

  typedef struct packed {
    flow_e pc;
    flow_e de;
    flow_e ex;
    flow_e mem;
    flow_e wb;
  } flow_vec_t;

  function automatic flow_vec_t flow_all(input flow_e code);
    return '{pc: code, de: code, ex: code, mem: code, wb: code};
  endfunction

endpackage

// File: rtl/flow_stall_cnt.sv
// 32-bit saturating event counter: counts clk edges with inc high, sticks at all-ones.
module flow_stall_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [31:0] count
);

  // NOTE: asynchronous active-low reset lives in the sensitivity list; the counter
  // holds its value (no assignment) when not incrementing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/rooth_defines.v
// Shared pipeline flow-code and flow-controller state encodings for the rooth core.
// Included once by the flow_ctrl package; include-guarded for reuse elsewhere.
`ifndef ROOTH_DEFINES_V
`define ROOTH_DEFINES_V

`define FLOW_WIDTH       2
`define FLOW_WORK        2'b00
`define FLOW_STOP        2'b01
`define FLOW_REFRESH     2'b10

`define ROOTH_ST_INIT    2'd0
`define ROOTH_ST_RUN     2'd1
`define ROOTH_ST_MD_WAIT 2'd2
`define ROOTH_ST_HALT    2'd3

`endif

// File: rtl/flow_ctrl.sv
// Pipeline flow controller: drives WORK/STOP/REFRESH codes for every pipeline register.
// Optional multi-cycle mul/div wait state is built only when ROOTH_MULDIV_EN is defined.
module flow_ctrl
  import flow_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_hazard_i,
  input  logic                  jump_i,
  input  logic                  md_start_i,
  input  logic                  md_done_i,
  input  logic                  halt_i,
  output logic [FLOW_WIDTH-1:0] flow_pc_o,
  output logic [FLOW_WIDTH-1:0] flow_de_o,
  output logic [FLOW_WIDTH-1:0] flow_ex_o,
  output logic [FLOW_WIDTH-1:0] flow_mem_o,
  output logic [FLOW_WIDTH-1:0] flow_wb_o,
  output logic [31:0]           stall_cnt_o
);

  // INIT always lasts at least one cycle, even with INIT_CYCLES = 0.
  localparam int INIT_LAST = (INIT_CYCLES > 0) ? INIT_CYCLES - 1 : 0;
  localparam int ICW       = (INIT_LAST > 0) ? $clog2(INIT_LAST + 1) : 1;

  state_e         state_q, state_d;
  logic [ICW-1:0] init_cnt_q;
  logic           init_done;
  run_ev_e        run_ev;
  flow_vec_t      flow;

`ifndef ROOTH_MULDIV_EN
  logic unused_md;
  assign unused_md = md_start_i ^ md_done_i;
`endif

  assign init_done = (init_cnt_q == ICW'(INIT_LAST));

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt_q <= '0;
    end else if ((state_q == ST_INIT) && !init_done) begin
      init_cnt_q <= init_cnt_q + ICW'(1);
    end
  end

  // NOTE: each always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    run_ev = EV_NONE;
    if (jump_i) begin
      run_ev = EV_JUMP;
    end
`ifdef ROOTH_MULDIV_EN
    else if (md_start_i) begin
      run_ev = EV_MD;
    end
`endif
    else if (halt_i) begin
      run_ev = EV_HALT;
    end else if (ld_hazard_i) begin
      run_ev = EV_LD;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT: if (init_done) state_d = ST_RUN;
      ST_RUN: begin
        if (run_ev == EV_MD)        state_d = ST_MD_WAIT;
        else if (run_ev == EV_HALT) state_d = ST_HALT;
      end
`ifdef ROOTH_MULDIV_EN
      ST_MD_WAIT: if (md_done_i) state_d = ST_RUN;
`endif
      ST_HALT: if (!halt_i) state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    flow = '{pc: FLOW_STOP, de: FLOW_REFRESH, ex: FLOW_REFRESH,
             mem: FLOW_REFRESH, wb: FLOW_REFRESH};
    unique case (state_q)
      ST_RUN: begin
        unique case (run_ev)
          EV_JUMP: flow = '{pc: FLOW_WORK, de: FLOW_REFRESH, ex: FLOW_REFRESH,
                            mem: FLOW_WORK, wb: FLOW_WORK};
          EV_MD:   flow = '{pc: FLOW_STOP, de: FLOW_STOP, ex: FLOW_STOP,
                            mem: FLOW_REFRESH, wb: FLOW_WORK};
          EV_HALT: flow = flow_all(FLOW_STOP);
          EV_LD:   flow = '{pc: FLOW_STOP, de: FLOW_STOP, ex: FLOW_REFRESH,
                            mem: FLOW_WORK, wb: FLOW_WORK};
          default: flow = flow_all(FLOW_WORK);
        endcase
      end
`ifdef ROOTH_MULDIV_EN
      ST_MD_WAIT: begin
        if (md_done_i) begin
          flow = flow_all(FLOW_WORK);
        end else begin
          flow = '{pc: FLOW_STOP, de: FLOW_STOP, ex: FLOW_STOP,
                   mem: FLOW_REFRESH, wb: FLOW_WORK};
        end
      end
`endif
      ST_HALT: flow = halt_i ? flow_all(FLOW_STOP) : flow_all(FLOW_WORK);
      default: ;
    endcase
  end

  assign flow_pc_o  = flow.pc;
  assign flow_de_o  = flow.de;
  assign flow_ex_o  = flow.ex;
  assign flow_mem_o = flow.mem;
  assign flow_wb_o  = flow.wb;

  flow_stall_cnt u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   ((state_q != ST_INIT) && (flow.pc == FLOW_STOP)),
    .count (stall_cnt_o)
  );

endmodule

// File: tb/tb_flow_ctrl.sv
// Scoreboard bench for flow_ctrl: the driver queues hand-computed expectations,
// the monitor pops and compares one entry on each falling clock edge.
module tb_flow_ctrl;
  import flow_ctrl_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  ld_hazard_i = 1'b0;
  logic                  jump_i = 1'b0;
  logic                  md_start_i = 1'b0;
  logic                  md_done_i = 1'b0;
  logic                  halt_i = 1'b0;
  logic [FLOW_WIDTH-1:0] flow_pc_o, flow_de_o, flow_ex_o, flow_mem_o, flow_wb_o;
  logic [31:0]           stall_cnt_o;

  flow_ctrl #(.INIT_CYCLES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_hazard_i (ld_hazard_i),
    .jump_i      (jump_i),
    .md_start_i  (md_start_i),
    .md_done_i   (md_done_i),
    .halt_i      (halt_i),
    .flow_pc_o   (flow_pc_o),
    .flow_de_o   (flow_de_o),
    .flow_ex_o   (flow_ex_o),
    .flow_mem_o  (flow_mem_o),
    .flow_wb_o   (flow_wb_o),
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk = ~clk;

  localparam flow_vec_t V_W = '{FLOW_WORK, FLOW_WORK, FLOW_WORK, FLOW_WORK, FLOW_WORK};
  localparam flow_vec_t V_S = '{FLOW_STOP, FLOW_STOP, FLOW_STOP, FLOW_STOP, FLOW_STOP};
  localparam flow_vec_t V_I = '{FLOW_STOP, FLOW_REFRESH, FLOW_REFRESH, FLOW_REFRESH, FLOW_REFRESH};
  localparam flow_vec_t V_J = '{FLOW_WORK, FLOW_REFRESH, FLOW_REFRESH, FLOW_WORK, FLOW_WORK};
  localparam flow_vec_t V_L = '{FLOW_STOP, FLOW_STOP, FLOW_REFRESH, FLOW_WORK, FLOW_WORK};
  localparam flow_vec_t V_M = '{FLOW_STOP, FLOW_STOP, FLOW_STOP, FLOW_REFRESH, FLOW_WORK};

`ifdef ROOTH_MULDIV_EN
  localparam int B = 35;
`else
  localparam int B = 1;
`endif

  typedef struct packed {
    flow_vec_t   flows;
    logic [31:0] stall;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One cycle of stimulus: drive just after the rising edge, queue the expectation.
  task automatic step(input logic rst, input logic ld, input logic jmp, input logic mds,
                      input logic mdd, input logic hlt, input flow_vec_t exp,
                      input logic [31:0] exp_stall, input string name);
    @(posedge clk);
    #1;
    rst_n       = rst;
    ld_hazard_i = ld;
    jump_i      = jmp;
    md_start_i  = mds;
    md_done_i   = mdd;
    halt_i      = hlt;
    exp_q.push_back('{flows: exp, stall: exp_stall});
    name_q.push_back(name);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check({n, "_flow"}, 32'({flow_pc_o, flow_de_o, flow_ex_o, flow_mem_o, flow_wb_o}),
            32'(e.flows));
      check({n, "_stall"}, stall_cnt_o, e.stall);
    end
  end

  initial begin
    // reset, then INIT flush with inputs ignored
    step(0, 0, 0, 0, 0, 0, V_I, 0, "reset");
    step(0, 1, 1, 1, 1, 1, V_I, 0, "reset_busy_inputs");
    step(1, 0, 0, 0, 0, 0, V_I, 0, "init0");
    step(1, 1, 1, 1, 1, 1, V_I, 0, "init1_ignored");
    step(1, 0, 0, 0, 0, 0, V_W, 0, "run_first");

    // load hazard bubble, jump priority, stray md_done
    step(1, 1, 0, 0, 0, 0, V_L, 0, "ld_hazard");
    step(1, 0, 0, 0, 0, 0, V_W, 1, "after_ld");
    step(1, 1, 1, 0, 0, 1, V_J, 1, "jump_wins");
    step(1, 0, 0, 0, 0, 0, V_W, 1, "after_jump");
    step(1, 0, 0, 0, 1, 0, V_W, 1, "md_done_in_run");

`ifdef ROOTH_MULDIV_EN
    step(1, 0, 0, 1, 0, 0, V_M, 1, "md_start");
    for (int i = 1; i <= 32; i++) begin
      step(1, i == 5, i == 7, 0, 0, i == 9, V_M, 32'(1 + i), $sformatf("md_wait%0d", i));
    end
    step(1, 0, 0, 0, 1, 1, V_W, 34, "md_done");
    step(1, 0, 0, 0, 0, 1, V_S, 34, "md_halt_deferred");
    step(1, 0, 0, 0, 0, 0, V_W, 35, "md_halt_release");
`else
    step(1, 0, 0, 1, 0, 0, V_W, 1, "md_start_ignored");
    step(1, 0, 0, 0, 1, 0, V_W, 1, "md_done_ignored");
`endif

    // five halt cycles then release
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 0, 1, V_S, 32'(B + i), $sformatf("halt%0d", i));
    end
    step(1, 0, 0, 0, 0, 0, V_W, 32'(B + 5), "halt_release");
    step(1, 0, 0, 0, 0, 0, V_W, 32'(B + 5), "after_halt");

    // asynchronous reset in the middle of a stall state
`ifdef ROOTH_MULDIV_EN
    step(1, 0, 0, 1, 0, 0, V_M, 32'(B + 5), "pre_rst_md_start");
    step(1, 0, 0, 0, 0, 0, V_M, 32'(B + 6), "pre_rst_md_wait");
`else
    step(1, 0, 0, 0, 0, 1, V_S, 32'(B + 5), "pre_rst_halt0");
    step(1, 0, 0, 0, 0, 1, V_S, 32'(B + 6), "pre_rst_halt1");
`endif
    step(0, 0, 0, 0, 0, 0, V_I, 0, "rst_mid");
    step(0, 0, 0, 0, 1, 0, V_I, 0, "rst_hold");
    step(1, 0, 0, 0, 0, 0, V_I, 0, "post_rst_init0");
    step(1, 0, 0, 0, 0, 0, V_I, 0, "post_rst_init1");
    step(1, 0, 0, 0, 1, 0, V_W, 0, "post_rst_run");
    step(1, 0, 0, 0, 0, 0, V_W, 0, "post_rst_idle");

    // saturation: preload near the top, then three stall cycles
    @(posedge clk);
    #2;
    force dut.u_stall_cnt.count = 32'hFFFF_FFFE;
    #1;
    release dut.u_stall_cnt.count;
    step(1, 0, 0, 0, 0, 1, V_S, 32'hFFFF_FFFE, "sat_halt0");
    step(1, 0, 0, 0, 0, 1, V_S, 32'hFFFF_FFFF, "sat_halt1");
    step(1, 0, 0, 0, 0, 1, V_S, 32'hFFFF_FFFF, "sat_halt2");
    step(1, 0, 0, 0, 0, 0, V_W, 32'hFFFF_FFFF, "sat_release");
    step(1, 0, 0, 0, 0, 0, V_W, 32'hFFFF_FFFF, "sat_idle");

    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
